// File: rtl/mac_dotprod_pkg.sv
// Shared constants and helpers for the streaming dot-product MAC.
// Optional feature macro: MAC_DOTPROD_SATURATE_EN (saturating accumulate + ovf tag).
package mac_dotprod_pkg;

  localparam int PIPE_LAT  = 4;
  localparam int MAX_LANES = 16;
  localparam int MAX_WIDTH = 18;
  localparam int MAX_BUS_W = MAX_LANES * MAX_WIDTH;

  typedef logic [MAX_BUS_W-1:0] bus_t;

`ifdef MAC_DOTPROD_SATURATE_EN
  // Per-entry tag that rides alongside each result in the output FIFO.
  typedef struct packed {
    logic ovf;
  } mac_tag_t;
`endif

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Width that holds the exact sum of LANES signed WIDTH x WIDTH products.
  function automatic int sum_w(input int lanes, input int width);
    return 2 * width + clog2(lanes);
  endfunction

  // Extract lane k (w bits wide) from a packed bus and sign-extend it.
  function automatic logic signed [MAX_WIDTH-1:0] lane_slice(input bus_t v, input int k,
                                                             input int w);
    bus_t                        sh;
    logic signed [MAX_WIDTH-1:0] r;
    sh = v >> (k * w);
    for (int i = 0; i < MAX_WIDTH; i++) r[i] = (i < w) ? sh[i] : sh[w-1];
    return r;
  endfunction

endpackage

// File: rtl/mac_dotprod_outfifo.sv
// First-word-fall-through output FIFO with occupancy count.
// Storage is not reset; only pointers and count are.
module mac_dotprod_outfifo
  import mac_dotprod_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A push into a full FIFO only lands when a pop frees the slot the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  // Data storage write port.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Pointer and occupancy tracking; push+pop leaves count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mac_dotprod_stream.sv
// Streaming signed dot-product MAC with group accumulation and a
// credit-checked FWFT output FIFO. Fixed 4-stage pipeline that never stalls;
// backpressure is absorbed entirely by refusing beats when no credit is left.
// Optional feature macro: MAC_DOTPROD_SATURATE_EN adds a saturating
// accumulate and an 'ovf' output that flags any clipped add in the group.
module mac_dotprod_stream
  import mac_dotprod_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_W     = 32,
  parameter int OUT_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    ivalid,
  output logic                    oready,
  input  logic [LANES*WIDTH-1:0]  dataa,
  input  logic [LANES*WIDTH-1:0]  datab,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic                    iready,
  output logic                    ovalid,
  output logic signed [ACC_W-1:0] result
`ifdef MAC_DOTPROD_SATURATE_EN
  ,
  output logic                    ovf
`endif
);

  localparam int STAGES = PIPE_LAT;
  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = sum_w(LANES, WIDTH);
  localparam int CNT_W  = clog2(OUT_DEPTH + 1);

  typedef struct packed {
`ifdef MAC_DOTPROD_SATURATE_EN
    mac_tag_t         tag;
`endif
    logic [ACC_W-1:0] res;
  } entry_t;

  localparam int ENT_W = $bits(entry_t);

  // ---------------- accept / credit ----------------
  logic              w_accept;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [CNT_W-1:0]  r_inflight;
  logic [CNT_W:0]    w_used;
  logic              w_push;
  logic              w_empty;

  assign w_accept = ivalid && oready;
  assign w_used   = {1'b0, w_fifo_cnt} + {1'b0, r_inflight};
  // Credit counts both queued results and i_last beats still in the pipe,
  // so the FIFO can never be asked to take more than it holds.
  assign oready   = !resetn && (w_used < (CNT_W + 1)'(OUT_DEPTH));

  // Track accepted i_last beats until their result is pushed.
  always_ff @(posedge clock) begin
    if (resetn) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept && i_last, w_push})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // ---------------- pipeline control ----------------
  logic [STAGES:1] r_vld_pipe;
  logic [3:1]      r_first_pipe;
  logic [STAGES:1] r_last_pipe;

  // Valid and group flags advance one stage per cycle unconditionally.
  always_ff @(posedge clock) begin
    if (resetn) begin
      r_vld_pipe   <= '0;
      r_first_pipe <= '0;
      r_last_pipe  <= '0;
    end else begin
      r_vld_pipe   <= {r_vld_pipe[STAGES-1:1], w_accept};
      r_first_pipe <= {r_first_pipe[2:1], i_first};
      r_last_pipe  <= {r_last_pipe[STAGES-1:1], i_last};
    end
  end

  // ---------------- S1: operand capture ----------------
  logic [LANES*WIDTH-1:0] r_a, r_b;
  bus_t                   w_a_bus, w_b_bus;

  // Operands only load on an accepted beat.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_a <= dataa;
      r_b <= datab;
    end
  end

  assign w_a_bus = bus_t'(r_a);
  assign w_b_bus = bus_t'(r_b);

  // ---------------- S2: lane products ----------------
  logic [LANES-1:0][PROD_W-1:0] w_prod;
  logic [LANES-1:0][PROD_W-1:0] r_prod;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [PROD_W-1:0] w_ea, w_eb;
    assign w_ea      = PROD_W'(lane_slice(w_a_bus, k, WIDTH));
    assign w_eb      = PROD_W'(lane_slice(w_b_bus, k, WIDTH));
    assign w_prod[k] = w_ea * w_eb;
  end

  // Product register stage.
  always_ff @(posedge clock) begin
    r_prod <= w_prod;
  end

  // ---------------- S3: lane reduction ----------------
  logic signed [SUM_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_sum;

  // Exact signed sum of all lane products (SUM_W cannot overflow).
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++) w_sum = w_sum + SUM_W'($signed(r_prod[k]));
  end

  // Sum register, sign-extended to accumulator width.
  always_ff @(posedge clock) begin
    r_sum <= ACC_W'(w_sum);
  end

  // ---------------- S4: accumulate ----------------
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;

`ifdef MAC_DOTPROD_SATURATE_EN
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [EXT_W-1:0] w_add;
  logic                    w_clip;
  logic                    r_ovf, w_ovf_nxt;

  // Saturating add with a group-sticky clip flag; a first beat restarts both.
  always_comb begin
    w_add     = EXT_W'(r_acc) + EXT_W'(r_sum);
    w_clip    = w_add[ACC_W] ^ w_add[ACC_W-1];
    w_acc_nxt = w_add[ACC_W-1:0];
    w_ovf_nxt = r_ovf;
    if (r_first_pipe[3]) begin
      w_acc_nxt = r_sum;
      w_ovf_nxt = 1'b0;
    end else if (w_clip) begin
      w_acc_nxt = w_add[ACC_W] ? ACC_MIN : ACC_MAX;
      w_ovf_nxt = 1'b1;
    end
  end

  // Sticky overflow flag register.
  always_ff @(posedge clock) begin
    if (resetn)             r_ovf <= 1'b0;
    else if (r_vld_pipe[3]) r_ovf <= w_ovf_nxt;
  end
`else
  // Wrapping add; a first beat replaces the accumulator.
  always_comb begin
    w_acc_nxt = r_first_pipe[3] ? r_sum : r_acc + r_sum;
  end
`endif

  // Accumulator; reset to zero so a headless group starts from 0.
  always_ff @(posedge clock) begin
    if (resetn)             r_acc <= '0;
    else if (r_vld_pipe[3]) r_acc <= w_acc_nxt;
  end

  // ---------------- output FIFO ----------------
  entry_t w_push_ent, w_head;
  logic   w_pop;

  assign w_push = r_vld_pipe[STAGES] && r_last_pipe[STAGES];

  // Pack the finished group result (and tag) into a FIFO entry.
  always_comb begin
    w_push_ent     = '0;
    w_push_ent.res = r_acc;
`ifdef MAC_DOTPROD_SATURATE_EN
    w_push_ent.tag.ovf = r_ovf;
`endif
  end

  mac_dotprod_outfifo #(
    .DW    (ENT_W),
    .DEPTH (OUT_DEPTH)
  ) u_outfifo (
    .i_clk   (clock),
    .i_rst   (resetn),
    .i_push  (w_push),
    .i_din   (w_push_ent),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt)
  );

  // Outputs are masked during reset so stale FIFO contents never leak.
  assign ovalid = !resetn && !w_empty;
  assign w_pop  = ovalid && iready;
  assign result = ovalid ? $signed(w_head.res) : '0;
`ifdef MAC_DOTPROD_SATURATE_EN
  assign ovf    = ovalid ? w_head.tag.ovf : 1'b0;
`endif

endmodule

// File: tb/tb_mac_dotprod_stream.sv
// Scoreboard bench for mac_dotprod_stream: stimulus pushes expected results
// from an arithmetic reference model; monitors pop and compare on each output.
module tb_mac_dotprod_stream;

  localparam int LANES = 4, WIDTH = 8, ACC_W = 32, OUT_DEPTH = 8, ACC_W2 = 18;
  localparam int BW = LANES * WIDTH;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                    resetn, ivalid, oready, i_first, i_last, iready, ovalid;
  logic [BW-1:0]           dataa, datab;
  logic signed [ACC_W-1:0] result;
  logic                    ivalid2, oready2, i_first2, i_last2, iready2, ovalid2;
  logic [BW-1:0]           dataa2, datab2;
  logic signed [ACC_W2-1:0] result2;
`ifdef MAC_DOTPROD_SATURATE_EN
  logic ovf, ovf2;
`endif

  mac_dotprod_stream #(.LANES(LANES), .WIDTH(WIDTH), .ACC_W(ACC_W), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready), .dataa(dataa),
    .datab(datab), .i_first(i_first), .i_last(i_last), .iready(iready), .ovalid(ovalid),
    .result(result)
`ifdef MAC_DOTPROD_SATURATE_EN
    , .ovf(ovf)
`endif
  );

  mac_dotprod_stream #(.LANES(LANES), .WIDTH(WIDTH), .ACC_W(ACC_W2), .OUT_DEPTH(OUT_DEPTH)) dut2 (
    .clock(clock), .resetn(resetn), .ivalid(ivalid2), .oready(oready2), .dataa(dataa2),
    .datab(datab2), .i_first(i_first2), .i_last(i_last2), .iready(iready2), .ovalid(ovalid2),
    .result(result2)
`ifdef MAC_DOTPROD_SATURATE_EN
    , .ovf(ovf2)
`endif
  );

  int checks = 0, errors = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint res; bit ovf; } exp_t;
  exp_t   q1[$], q2[$];
  longint m_acc[2];
  bit     m_ovf[2];

  function automatic logic [BW-1:0] pk(input int v0, input int v1, input int v2, input int v3);
    return {WIDTH'(v3), WIDTH'(v2), WIDTH'(v1), WIDTH'(v0)};
  endfunction

  function automatic longint dot(input logic [BW-1:0] a, input logic [BW-1:0] b);
    longint s = 0;
    logic signed [WIDTH-1:0] la, lb;
    for (int k = 0; k < LANES; k++) begin
      la = a[k*WIDTH +: WIDTH];
      lb = b[k*WIDTH +: WIDTH];
      s += longint'(la) * longint'(lb);
    end
    return s;
  endfunction

  task automatic model_beat(input int sel, input logic [BW-1:0] a, input logic [BW-1:0] b,
                            input bit f, input bit l);
    int     w = (sel == 0) ? ACC_W : ACC_W2;
    longint m = longint'(1) << w;
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint mn = -(longint'(1) << (w - 1));
    longint s;
    exp_t   e;
    if (f) begin
      m_acc[sel] = dot(a, b);
      m_ovf[sel] = 1'b0;
    end else begin
      s = m_acc[sel] + dot(a, b);
`ifdef MAC_DOTPROD_SATURATE_EN
      if (s > mx) begin s = mx; m_ovf[sel] = 1'b1; end
      else if (s < mn) begin s = mn; m_ovf[sel] = 1'b1; end
`else
      s = s % m;
      if (s > mx) s -= m;
      if (s < mn) s += m;
`endif
      m_acc[sel] = s;
    end
    if (l) begin
      e.res = m_acc[sel];
      e.ovf = m_ovf[sel];
      if (sel == 0) q1.push_back(e); else q2.push_back(e);
    end
  endtask

  // ---------------- monitors ----------------
  exp_t e1, e2;

  always @(negedge clock) begin
    if (ovalid && iready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out actual=%0d required=none", result);
      end else begin
        e1 = q1.pop_front();
        check("result", result, e1.res);
`ifdef MAC_DOTPROD_SATURATE_EN
        check("ovf", ovf, e1.ovf);
`endif
      end
    end
  end

  always @(negedge clock) begin
    if (ovalid2 && iready2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out2 actual=%0d required=none", result2);
      end else begin
        e2 = q2.pop_front();
        check("result2", result2, e2.res);
`ifdef MAC_DOTPROD_SATURATE_EN
        check("ovf2", ovf2, e2.ovf);
`endif
      end
    end
  end

  // ---------------- drivers (call between posedge and negedge) ----------------
  task automatic send1(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit f, input bit l);
    bit ok = 0;
    int n = 0;
    dataa = a; datab = b; i_first = f; i_last = l; ivalid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clock);
      if (oready) ok = 1;
      @(posedge clock); #1;
      n++;
    end
    ivalid = 1'b0;
    check("accept", ok, 1);
    if (ok) model_beat(0, a, b, f, l);
  endtask

  task automatic send2(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit f, input bit l);
    bit ok = 0;
    int n = 0;
    dataa2 = a; datab2 = b; i_first2 = f; i_last2 = l; ivalid2 = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clock);
      if (oready2) ok = 1;
      @(posedge clock); #1;
      n++;
    end
    ivalid2 = 1'b0;
    check("accept2", ok, 1);
    if (ok) model_beat(1, a, b, f, l);
  endtask

  task automatic drain(input int sel);
    int n = 0;
    while (((sel == 0) ? q1.size() : q2.size()) != 0 && n < 400) begin
      @(posedge clock);
      n++;
    end
    #1;
    check((sel == 0) ? "drain" : "drain2", (sel == 0) ? q1.size() : q2.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  bit done;
  logic [BW-1:0] ones;

  initial begin
    resetn = 1'b1; ivalid = 0; i_first = 0; i_last = 0; iready = 1; dataa = '0; datab = '0;
    ivalid2 = 0; i_first2 = 0; i_last2 = 0; iready2 = 1; dataa2 = '0; datab2 = '0;
    m_acc = '{0, 0}; m_ovf = '{0, 0};
    ones = pk(1, 1, 1, 1);

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_oready", oready, 0);
    check("rst_ovalid", ovalid, 0);
    check("rst_result", result, 0);
    @(posedge clock); #1 resetn = 1'b0;
    @(negedge clock);
    check("post_rst_oready", oready, 1);
    check("post_rst_ovalid", ovalid, 0);
    check("post_rst_result", result, 0);
    @(posedge clock); #1;

    // single beat: result 70, ovalid exactly 5 cycles after accept
    send1(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1, 1);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      check("lat_ovalid", ovalid, (n == 5));
    end
    @(posedge clock); #1;

    // operand extremes
    send1(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1, 1);
    send1(pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1, 1);
    drain(0);

    // 3-beat group: 10 + (-3) + 100
    send1(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 1, 0);
    send1(pk(1, -2, 0, 0), pk(1, 2, 0, 0), 0, 0);
    send1(pk(10, 0, 0, 0), pk(10, 0, 0, 0), 0, 1);
    drain(0);

    // backpressure: 8 credits, then release
    @(posedge clock); #1 iready = 1'b0;
    for (int i = 0; i < 8; i++) send1(BW'($urandom), BW'($urandom), 1, 1);
    @(negedge clock);
    check("bp_oready_drop", oready, 0);
    repeat (6) @(negedge clock);
    check("bp_full_ovalid", ovalid, 1);
    check("bp_full_oready", oready, 0);
    @(posedge clock); #1 iready = 1'b1;
    @(negedge clock);
    check("bp_oready_not_comb", oready, 0);
    @(negedge clock);
    check("bp_oready_recover", oready, 1);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) send1(BW'($urandom), BW'($urandom), 1, 1);
    drain(0);

    // reset mid-stream: 3 queued results plus a half-accumulated group
    iready = 1'b0;
    for (int i = 0; i < 3; i++) send1(BW'($urandom), BW'($urandom), 1, 1);
    send1(pk(50, 60, 70, 80), pk(9, 9, 9, 9), 1, 0);
    repeat (6) @(posedge clock);
    #1 resetn = 1'b1; iready = 1'b1;
    q1.delete(); m_acc[0] = 0; m_ovf[0] = 0;
    @(negedge clock);
    check("mid_rst_ovalid", ovalid, 0);
    check("mid_rst_oready", oready, 0);
    @(posedge clock); #1 resetn = 1'b0;
    @(negedge clock);
    check("after_rst_ovalid", ovalid, 0);
    check("after_rst_result", result, 0);
    check("after_rst_oready", oready, 1);
    @(posedge clock); #1;
    send1(ones, ones, 0, 1);   // headless beat accumulates onto a cleared acc
    drain(0);

    // randomized groups with random downstream readiness
    done = 0;
    fork
      begin
        for (int g = 0; g < 30; g++) begin
          int len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++)
            send1(BW'($urandom), BW'($urandom), (j == 0), (j == len - 1));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clock); #1;
          iready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    iready = 1'b1;
    drain(0);

    // narrow accumulator: 3 x 65536 in an 18-bit acc
    for (int j = 0; j < 3; j++)
      send2(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), (j == 0), (j == 2));
    drain(1);

    repeat (5) @(posedge clock);
    check("final_q1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_dotprod_stream.md
Name: mac_dotprod_stream

Overview:
- Parametrised successor to the fixed 4-lane 8-bit DSP MAC used as an OpenCL RTL library function.
- Computes a signed dot product over LANES lanes of WIDTH-bit operands each beat.
- Optionally accumulates the dot product across a multi-beat group delimited by first/last flags.
- Real valid/ready flow control via a credit-checked output FIFO; sits between the PE operand feeders and the PE output drain.

Parameters:
- LANES, 4, number of multiply lanes (1..16).
- WIDTH, 8, signed operand width per lane (2..18).
- ACC_W, 32, accumulator and result width; must be >= 2*WIDTH+clog2(LANES).
- OUT_DEPTH, 8, output FIFO entries; must be >= PIPE_LAT+1.

Ports:
- clock  in  1  sole clock.
- resetn  in  1  reset, synchronous, active-high: a sampled 1 resets the block. Port name follows the library interface.
- ivalid  in  1  input beat valid.
- oready  out  1  block can accept a beat this cycle.
- dataa  in  LANES*WIDTH  packed signed operands; lane k = [k*WIDTH +: WIDTH].
- datab  in  LANES*WIDTH  packed signed operands, same packing.
- i_first  in  1  beat starts a group; clears the accumulator.
- i_last  in  1  beat ends a group; produces one result.
- iready  in  1  downstream ready.
- ovalid  out  1  result valid.
- result  out  ACC_W  signed result.

Behaviour:
- Accept: a beat is accepted when ivalid && oready. Beats with ivalid=1 and oready=0 are ignored; upstream holds them.
- Pipeline, PIPE_LAT=4, never stalls:
  - S1: register operands and flags.
  - S2: LANES signed products, 2*WIDTH bits each.
  - S3: adder tree, sign-extended to ACC_W.
  - S4: accumulate.
- Accumulator rules at S4:
  - i_first=1: acc <= sum.
  - i_first=0: acc <= acc + sum (two's-complement wrap).
  - i_first && i_last: single-beat group; result = sum.
- Output: on an S4 beat with i_last=1, the new acc value is pushed into the output FIFO.
  - Accepted-to-FIFO latency: 4 cycles.
  - ovalid can assert in the cycle after the push: 5 cycles accept-to-ovalid when the FIFO is empty.
- FIFO: first-word-fall-through. ovalid = !empty; result = head. Pop on ovalid && iready.
- Credit:
  - inflight = count of accepted i_last beats not yet pushed.
  - oready = (fifo_count + inflight) < OUT_DEPTH.
  - The FIFO therefore never overflows.
  - Non-last beats are always accepted while a credit exists.
- Simultaneous push and pop: count unchanged, data order preserved.
- Full FIFO with iready=1: pop frees a credit; oready rises the next cycle, not combinationally.
- A beat without i_first that follows reset accumulates onto acc=0.
- Reset:
  - All pipeline valid bits, FIFO pointers, count, inflight and acc go to 0.
  - ovalid=0 and result=0 during reset and in the cycle after.
  - oready=0 while resetn=1; oready=1 the first cycle after deassert.
  - Reset mid-group or with a full FIFO discards all in-flight data; no partial result is emitted.

Optional Feature:
- Macro: MAC_DOTPROD_SATURATE_EN.
- Defined:
  - The S4 add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A sticky overflow flag travels with each FIFO entry.
  - Extra output port ovf (1 bit) is valid with ovalid.
  - ovf is set if any add in that group clipped.
- Undefined: the add wraps; no ovf port; zero extra logic.

Decomposition:
- Package mac_dotprod_pkg holds:
  - PIPE_LAT=4.
  - function clog2.
  - function sum width SUM_W(LANES,WIDTH).
  - lane-slice helper.
  - typedef for the FIFO entry (result plus optional ovf).
- One sub-module: mac_dotprod_outfifo (FWFT, depth OUT_DEPTH, count output). Top instantiates it.
- Multiplier/adder tree is inferred inline in generate loops.

Test Plan:
- Single beat, LANES=4, WIDTH=8: a=(1,2,3,4), b=(5,6,7,8), first=last=1 -> exactly one ovalid, 5 cycles after accept, result=70.
- Extremes: all a=-128, all b=-128 -> result=65536; all a=-128, b=127 -> result=-65024, sign-extended to 32 bits (0xFFFF_0200).
- Group of 3 beats (first on beat 0, last on beat 2): sums 10, -3, 100 -> one result, 107; no ovalid for the non-last beats.
- Backpressure with OUT_DEPTH=8: hold iready=0 and stream 12 single-beat groups.
  - oready drops after 8 accepted.
  - Release iready=1: all 12 results emerge in order.
  - No loss or duplication; oready recovers one cycle after the first pop.
- Reset mid-stream: assert resetn=1 for 1 cycle with 3 results queued and a group half-accumulated.
  - ovalid=0 next cycle; the FIFO is empty.
  - A following group a=b=(1,1,1,1) gives 4, not 4 plus stale acc.
- With MAC_DOTPROD_SATURATE_EN, ACC_W=18: accumulate 3 beats of 65536 -> result=131071, ovf=1.
- Without the macro, the same stimulus -> result=-65536 (0x3_0000 wrapped to 18 bits, sign-extended).
